// File: rtl/bit_slicer.sv
// bit_slicer: splits one dual-rail (1-of-2 per bit) four-phase token into a
// data field and an address field, each on its own four-phase output channel.
//
// Ports:
//   CLK     in   rising-edge clock
//   RESET   in   synchronous, active-high reset
//   in_d    in   dual-rail input word; bit i -> in_d[2i] rail0, in_d[2i+1] rail1
//   in_e    out  input enable/ack (1 = ready for data, 0 = token consumed)
//   data_d  out  dual-rail data field  = in[W_DATA-1:0]
//   data_e  in   data channel enable from receiver
//   addr_d  out  dual-rail address field = in[W_IN-1:W_DATA]
//   addr_e  in   address channel enable from receiver
//
// All outputs come straight from flops. The FSM is split into a state
// register, a next-state process and an output (next-register-value) process.
module bit_slicer #(
  parameter int W_IN   = 11,
  parameter int W_DATA = 7,
  parameter int W_ADDR = 4
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [2*W_IN-1:0]     in_d,
  output logic                  in_e,
  output logic [2*W_DATA-1:0]   data_d,
  input  logic                  data_e,
  output logic [2*W_ADDR-1:0]   addr_d,
  input  logic                  addr_e
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_RTZ  = 2'd2
  } state_t;

  // One bit per group: set when exactly one rail of the group is high.
  function automatic logic [W_IN-1:0] rail_valid(input logic [2*W_IN-1:0] w);
    logic [W_IN-1:0] v;
    v = {W_IN{1'b0}};
    for (int i = 0; i < W_IN; i++) begin
      v[i] = w[2*i] ^ w[2*i+1];
    end
    return v;
  endfunction

  // Binary value carried by a word; only meaningful when every group is valid.
  function automatic logic [W_IN-1:0] rail_value(input logic [2*W_IN-1:0] w);
    logic [W_IN-1:0] v;
    v = {W_IN{1'b0}};
    for (int i = 0; i < W_IN; i++) begin
      v[i] = w[2*i+1];
    end
    return v;
  endfunction

  // Binary to dual-rail: each bit becomes {rail1, rail0} = {b, ~b}.
  function automatic logic [2*W_IN-1:0] rail_encode(input logic [W_IN-1:0] v);
    logic [2*W_IN-1:0] w;
    w = {2*W_IN{1'b0}};
    for (int i = 0; i < W_IN; i++) begin
      w[2*i]   = ~v[i];
      w[2*i+1] = v[i];
    end
    return w;
  endfunction

  state_t                state_r;
  state_t                state_nxt_s;
  logic                  in_e_r;
  logic                  in_e_nxt_s;
  logic [2*W_DATA-1:0]   data_d_r;
  logic [2*W_DATA-1:0]   data_d_nxt_s;
  logic [2*W_ADDR-1:0]   addr_d_r;
  logic [2*W_ADDR-1:0]   addr_d_nxt_s;

  logic                  word_valid_s;
  logic                  word_neutral_s;
  logic                  outs_neutral_s;
  logic                  capture_s;
  logic [2*W_IN-1:0]     enc_s;

  // Word classification. Re-encoding the decoded value (rather than copying
  // in_d) guarantees an illegal group can never reach an output rail.
  assign word_valid_s   = &rail_valid(in_d);
  assign word_neutral_s = (in_d == {2*W_IN{1'b0}});
  assign outs_neutral_s = (data_d_r == {2*W_DATA{1'b0}}) &&
                          (addr_d_r == {2*W_ADDR{1'b0}});
  assign capture_s      = word_valid_s && data_e && addr_e;
  assign enc_s          = rail_encode(rail_value(in_d));

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (capture_s) begin
          state_nxt_s = ST_SEND;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SEND: begin
        // Both receivers done and the source has returned to zero.
        if (outs_neutral_s && word_neutral_s) begin
          state_nxt_s = ST_RTZ;
        end else begin
          state_nxt_s = ST_SEND;
        end
      end
      ST_RTZ: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Output logic: next values for the registered channel outputs.
  always_comb begin
    in_e_nxt_s   = in_e_r;
    data_d_nxt_s = data_d_r;
    addr_d_nxt_s = addr_d_r;
    case (state_r)
      ST_IDLE: begin
        if (capture_s) begin
          data_d_nxt_s = enc_s[2*W_DATA-1:0];
          addr_d_nxt_s = enc_s[2*W_IN-1:2*W_DATA];
          in_e_nxt_s   = 1'b0;
        end else begin
          in_e_nxt_s   = 1'b1;
        end
      end
      ST_SEND: begin
        // Channels acknowledge independently; once neutral, a channel stays
        // neutral even if its receiver re-enables before the token completes.
        if (!data_e) begin
          data_d_nxt_s = {2*W_DATA{1'b0}};
        end else begin
          data_d_nxt_s = data_d_r;
        end
        if (!addr_e) begin
          addr_d_nxt_s = {2*W_ADDR{1'b0}};
        end else begin
          addr_d_nxt_s = addr_d_r;
        end
      end
      ST_RTZ: begin
        in_e_nxt_s = 1'b1;
      end
      default: begin
        in_e_nxt_s   = 1'b1;
        data_d_nxt_s = {2*W_DATA{1'b0}};
        addr_d_nxt_s = {2*W_ADDR{1'b0}};
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      in_e_r   <= 1'b1;
      data_d_r <= {2*W_DATA{1'b0}};
      addr_d_r <= {2*W_ADDR{1'b0}};
    end else begin
      in_e_r   <= in_e_nxt_s;
      data_d_r <= data_d_nxt_s;
      addr_d_r <= addr_d_nxt_s;
    end
  end

  assign in_e   = in_e_r;
  assign data_d = data_d_r;
  assign addr_d = addr_d_r;

endmodule

// File: tb/tb_bit_slicer.sv
// Self-checking bench for bit_slicer. Expected channel values come from a
// token-level model: data = v mod 128, addr = v div 128, and the handshake
// timing is predicted from when each ack and the input return-to-zero occur.
module tb_bit_slicer;

  logic        CLK;
  logic        RESET;
  logic [21:0] in_d;
  logic        in_e;
  logic [13:0] data_d;
  logic        data_e;
  logic [7:0]  addr_d;
  logic        addr_e;

  int n_checks;
  int n_errors;

  bit_slicer dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .in_d   (in_d),
    .in_e   (in_e),
    .data_d (data_d),
    .data_e (data_e),
    .addr_d (addr_d),
    .addr_e (addr_e)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // Dual-rail image of the low n bits of v.
  function automatic logic [31:0] dr(input int v, input int n);
    logic [31:0] r;
    int b;
    r = 32'd0;
    for (int i = 0; i < n; i++) begin
      b = (v >> i) & 1;
      r[2*i+1] = (b == 1);
      r[2*i]   = (b == 0);
    end
    return r;
  endfunction

  // One full four-phase transaction. ack_d/ack_a: cycle index (after capture)
  // at which each receiver drops its enable; hold: cycles the source keeps a
  // (different) valid word on in_d before going neutral.
  task automatic send_token(input int v, input int ack_d, input int ack_a, input int hold);
    int waited;
    int m;
    int t;
    logic [31:0] exp_d;
    logic [31:0] exp_a;
    waited = 0;
    while (!in_e && waited < 20) begin
      tick;
      waited++;
    end
    chk_eq("ready", {31'd0, in_e}, 32'd1);
    exp_d = dr(v % 128, 7);
    exp_a = dr(v / 128, 4);
    in_d = dr(v, 11);
    tick;
    chk_eq("cap_in_e", {31'd0, in_e}, 32'd0);
    chk_eq("cap_data", {18'd0, data_d}, exp_d);
    chk_eq("cap_addr", {24'd0, addr_d}, exp_a);
    m = (ack_d > ack_a) ? ack_d : ack_a;
    t = (((m + 1) > hold) ? (m + 1) : hold) + 1;
    for (int c = 0; c <= t; c++) begin
      if (c < hold) in_d = dr((~v) & 2047, 11);
      else          in_d = 22'd0;
      if (c == ack_d) data_e = 1'b0;
      if (c == ack_a) addr_e = 1'b0;
      tick;
      chk_eq("hs_data", {18'd0, data_d}, (c >= ack_d) ? 32'd0 : exp_d);
      chk_eq("hs_addr", {24'd0, addr_d}, (c >= ack_a) ? 32'd0 : exp_a);
      chk_eq("hs_in_e", {31'd0, in_e}, (c >= t) ? 32'd1 : 32'd0);
    end
    data_e = 1'b1;
    addr_e = 1'b1;
  endtask

  initial begin
    int v;
    n_checks = 0;
    n_errors = 0;
    RESET  = 1'b1;
    in_d   = 22'd0;
    data_e = 1'b0;
    addr_e = 1'b0;

    // Reset for 4 cycles, then release with receivers enabled.
    repeat (4) tick;
    RESET  = 1'b0;
    data_e = 1'b1;
    addr_e = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk_eq("rst_in_e", {31'd0, in_e}, 32'd1);
      chk_eq("rst_data", {18'd0, data_d}, 32'd0);
      chk_eq("rst_addr", {24'd0, addr_d}, 32'd0);
    end

    // Sequential source 1..20, acks one cycle after valid.
    for (int i = 1; i <= 20; i++) send_token(i, 1, 1, 0);

    // Boundary values.
    send_token(11'h7FF, 0, 0, 0);
    send_token(11'h3FF, 1, 0, 1);
    send_token(11'h480, 0, 2, 0);
    send_token(11'h000, 1, 1, 2);

    // Skewed acks on 0x123.
    send_token(11'h123, 1, 10, 0);
    // Input neutrality arriving well after both acks.
    send_token(11'h5A5, 0, 0, 6);

    // Partial word (group 5 neutral) must not be captured.
    in_d = dr(11'h3C5, 11);
    in_d[11:10] = 2'b00;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk_eq("part_in_e", {31'd0, in_e}, 32'd1);
      chk_eq("part_data", {18'd0, data_d}, 32'd0);
    end
    // Illegal group (both rails high) must not be captured either.
    in_d[11:10] = 2'b11;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk_eq("ill_in_e", {31'd0, in_e}, 32'd1);
      chk_eq("ill_addr", {24'd0, addr_d}, 32'd0);
    end
    in_d = 22'd0;
    tick;
    send_token(11'h055, 1, 1, 0);

    // Reset while outputs are valid.
    in_d = dr(11'h2AA, 11);
    tick;
    chk_eq("pre_rst_data", {18'd0, data_d}, dr(11'h2AA % 128, 7));
    RESET = 1'b1;
    in_d  = 22'd0;
    tick;
    chk_eq("mid_rst_data", {18'd0, data_d}, 32'd0);
    chk_eq("mid_rst_addr", {24'd0, addr_d}, 32'd0);
    chk_eq("mid_rst_in_e", {31'd0, in_e}, 32'd1);
    RESET = 1'b0;
    tick;
    send_token(11'h081, 1, 1, 0);

    // Randomized tokens with random ack skew and source hold time.
    for (int i = 0; i < 40; i++) begin
      v = int'($urandom_range(0, 2047));
      send_token(v, int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
                 int'($urandom_range(0, 4)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
